// File: rtl/core_dispatch_ctrl.sv
// Dual-core dispatch controller: queues core0 fork requests and sequences core1
// through register copy, PC load, run and join, with a watchdog on the run phase.
module core_dispatch_ctrl #(
   parameter int ADDR_W         = 32,
   parameter int REGCOPY_CYCLES = 4,
   parameter int TIMEOUT        = 1024,
   parameter int FIFO_DEPTH     = 2
) (
   input  logic                          sclk,
   input  logic                          reset,
   input  logic                          load,
   input  logic                          fork_valid,
   output logic                          fork_ready,
   input  logic [ADDR_W-1:0]             fork_pc,
   output logic                          join_valid,
   input  logic                          join_ack,
   output logic [ADDR_W-1:0]             join_pc,
   output logic                          join_timeout,
   output logic                          core1_wake,
   output logic                          core1_reg_runtime,
   output logic [ADDR_W-1:0]             core1_pc,
   output logic                          core1_pc_load,
   input  logic                          core1_exit,
   input  logic [ADDR_W-1:0]             core1_exit_pc,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   queue_count
);

   localparam int PW   = $clog2(FIFO_DEPTH);
   localparam int CC_W = $clog2(REGCOPY_CYCLES + 1);
   localparam int WD_W = $clog2(TIMEOUT);
   localparam logic [PW:0]     FULL_CNT = (PW+1)'(FIFO_DEPTH);
   localparam logic [CC_W-1:0] CC_LAST  = CC_W'(REGCOPY_CYCLES - 1);
   localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {S_IDLE, S_COPY, S_LAUNCH, S_RUN, S_JOIN} state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_mem [FIFO_DEPTH];
   logic [PW-1:0]     r_wr_ptr, r_rd_ptr;
   logic [PW:0]       r_count;
   logic [ADDR_W-1:0] r_cur_pc;
   logic [CC_W-1:0]   r_copy_cnt;
   logic [WD_W-1:0]   r_wd;
   logic              r_join_valid, r_join_timeout;
   logic [ADDR_W-1:0] r_join_pc, r_pc;
   logic              r_wake, r_regrt, r_pc_load;

   logic w_full, w_ready, w_push, w_pop;

   // Ready looks only at registered occupancy, so a same-cycle pop never frees a slot.
   assign w_full  = (r_count == FULL_CNT);
   assign w_ready = reset & ~load & ~w_full;
   assign w_push  = fork_valid & w_ready;
   assign w_pop   = (r_state == S_IDLE) & (r_count != '0);

   always_ff @(posedge sclk) begin
      if (w_push) r_mem[r_wr_ptr] <= fork_pc;
   end

   always_ff @(posedge sclk) begin
      if (!reset || load) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
      end
   end

   always_ff @(posedge sclk) begin
      if (!reset || load) begin
         r_state        <= S_IDLE;
         r_cur_pc       <= '0;
         r_copy_cnt     <= '0;
         r_wd           <= '0;
         r_join_valid   <= 1'b0;
         r_join_pc      <= '0;
         r_join_timeout <= 1'b0;
         r_wake         <= 1'b0;
         r_regrt        <= 1'b0;
         r_pc           <= '0;
         r_pc_load      <= 1'b0;
      end else begin
         r_pc_load <= 1'b0;
         unique case (r_state)
            S_IDLE: if (w_pop) begin
               r_cur_pc   <= r_mem[r_rd_ptr];
               r_copy_cnt <= CC_LAST;
               r_regrt    <= 1'b1;
               r_state    <= S_COPY;
            end
            S_COPY: if (r_copy_cnt == '0) begin
               r_regrt   <= 1'b0;
               r_pc_load <= 1'b1;
               r_pc      <= r_cur_pc;
               r_wd      <= '0;
               r_state   <= S_LAUNCH;
            end else begin
               r_copy_cnt <= r_copy_cnt - 1'b1;
            end
            S_LAUNCH: begin
               r_wake  <= 1'b1;
               r_wd    <= '0;
               r_state <= S_RUN;
            end
            S_RUN: begin
               r_wd <= r_wd + 1'b1;
               // A real exit wins over watchdog expiry in the same cycle.
               if (core1_exit) begin
                  r_join_pc      <= core1_exit_pc;
                  r_join_timeout <= 1'b0;
                  r_join_valid   <= 1'b1;
                  r_wake         <= 1'b0;
                  r_state        <= S_JOIN;
               end else if (r_wd == WD_LAST) begin
                  r_join_pc      <= r_cur_pc;
                  r_join_timeout <= 1'b1;
                  r_join_valid   <= 1'b1;
                  r_wake         <= 1'b0;
                  r_state        <= S_JOIN;
               end
            end
            S_JOIN: if (join_ack) begin
               r_join_valid   <= 1'b0;
               r_join_pc      <= '0;
               r_join_timeout <= 1'b0;
               r_pc           <= '0;
               r_state        <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign fork_ready        = w_ready;
   assign join_valid        = r_join_valid;
   assign join_pc           = r_join_pc;
   assign join_timeout      = r_join_timeout;
   assign core1_wake        = r_wake;
   assign core1_reg_runtime = r_regrt;
   assign core1_pc          = r_pc;
   assign core1_pc_load     = r_pc_load;
   assign busy              = (r_state != S_IDLE);
   assign queue_count       = r_count;

endmodule

// File: tb/tb_core_dispatch_ctrl.sv
// Bench for core_dispatch_ctrl: directed test-plan scenarios plus randomized
// traffic, checked every cycle against a timeline model of one dispatch job.
module tb_core_dispatch_ctrl;
   localparam int AW = 32, R = 4, TO = 16, D = 2;

   logic          sclk = 1'b0;
   logic          reset = 1'b0, load = 1'b0, fork_valid = 1'b0, join_ack = 1'b0, core1_exit = 1'b0;
   logic [AW-1:0] fork_pc = '0, core1_exit_pc = '0;
   logic          fork_ready, join_valid, join_timeout, core1_wake, core1_reg_runtime, core1_pc_load, busy;
   logic [AW-1:0] join_pc, core1_pc;
   logic [1:0]    queue_count;

   core_dispatch_ctrl #(.ADDR_W(AW), .REGCOPY_CYCLES(R), .TIMEOUT(TO), .FIFO_DEPTH(D)) dut (
      .sclk(sclk), .reset(reset), .load(load),
      .fork_valid(fork_valid), .fork_ready(fork_ready), .fork_pc(fork_pc),
      .join_valid(join_valid), .join_ack(join_ack), .join_pc(join_pc), .join_timeout(join_timeout),
      .core1_wake(core1_wake), .core1_reg_runtime(core1_reg_runtime), .core1_pc(core1_pc),
      .core1_pc_load(core1_pc_load), .core1_exit(core1_exit), .core1_exit_pc(core1_exit_pc),
      .busy(busy), .queue_count(queue_count));

   always #5 sclk = ~sclk;

   int n_chk = 0, n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Model: a job is "active" from the edge that pops it; m_t counts cycles
   // since that pop (1..R copy, R+1 load, then wake cycles until join).
   logic [AW-1:0] q[$];
   bit            m_act, m_jv, m_jto;
   int            m_t;
   logic [AW-1:0] m_cur, m_jpc;

   task automatic model_update();
      bit can_push;
      if (!reset || load) begin
         q.delete(); m_act = 0; m_jv = 0;
      end else begin
         can_push = (q.size() < D);
         if (!m_act) begin
            if (q.size() > 0) begin m_cur = q.pop_front(); m_act = 1; m_t = 1; end
         end else if (m_jv) begin
            if (join_ack) begin m_act = 0; m_jv = 0; end
         end else if (m_t >= R + 2) begin
            if (core1_exit) begin m_jv = 1; m_jpc = core1_exit_pc; m_jto = 0; end
            else if (m_t - (R + 1) == TO) begin m_jv = 1; m_jpc = m_cur; m_jto = 1; end
            else m_t++;
         end else m_t++;
         if (fork_valid && can_push) q.push_back(fork_pc);
      end
   endtask

   task automatic check_outs();
      bit run = m_act && !m_jv;
      chk("busy",        busy, m_act);
      chk("queue_count", queue_count, q.size());
      chk("reg_runtime", core1_reg_runtime, run && m_t <= R);
      chk("pc_load",     core1_pc_load, run && m_t == R + 1);
      chk("wake",        core1_wake, run && m_t >= R + 2);
      chk("core1_pc",    core1_pc, (m_act && m_t >= R + 1) ? m_cur : '0);
      chk("join_valid",  join_valid, m_jv);
      chk("join_pc",     join_pc, m_jv ? m_jpc : '0);
      chk("join_to",     join_timeout, m_jv && m_jto);
   endtask

   task automatic step();
      @(negedge sclk);
      chk("fork_ready", fork_ready, reset && !load && (q.size() < D));
      @(posedge sclk);
      model_update();
      #1 check_outs();
   endtask

   task automatic flush();
      fork_valid = 0; core1_exit = 0; join_ack = 0;
      load = 1; step(); load = 0; step();
   endtask

   task automatic single_fork(input logic [AW-1:0] pc, input logic [AW-1:0] xpc);
      fork_valid = 1; fork_pc = pc; step(); fork_valid = 0;
      for (int k = 2; k <= 10; k++) begin
         step();
         chk("tp_regrt", core1_reg_runtime, (k >= 2 && k <= 5));
         chk("tp_pcload", core1_pc_load, (k == 6));
         chk("tp_wake", core1_wake, (k >= 7));
         if (k == 6) chk("tp_pc", core1_pc, pc);
      end
      core1_exit = 1; core1_exit_pc = xpc; step(); core1_exit = 0;
      repeat (3) begin
         chk("tp_jv", join_valid, 1); chk("tp_jpc", join_pc, xpc); chk("tp_jto", join_timeout, 0);
         step();
      end
      join_ack = 1; step(); join_ack = 0;
      chk("tp_jclr", join_valid, 0);
   endtask

   task automatic run_to_load(input logic [AW-1:0] pc);
      int i;
      for (i = 0; i < 20 && !core1_pc_load; i++) step();
      chk("dispatch_pc", core1_pc_load ? core1_pc : '1, pc);
      core1_exit = 1; step(); step(); core1_exit = 0;
      join_ack = 1; step(); join_ack = 0;
   endtask

   initial begin
      int nw;
      int ex_pct;
      step(); step();
      chk("rst_busy", busy, 0); chk("rst_qc", queue_count, 0); chk("rst_jv", join_valid, 0);
      reset = 1; step();

      single_fork('h100, 'h1A4);

      // Queue fill while core1 runs, then join backpressure.
      fork_valid = 1; fork_pc = 'h1000; step();
      fork_pc = 'h200; step(); fork_pc = 'h300; step();
      fork_pc = 'h400;
      chk("qf_count", queue_count, 2); chk("qf_ready", fork_ready, 0);
      step(); fork_valid = 0;
      for (int i = 0; i < 30 && !core1_wake; i++) step();
      core1_exit = 1; core1_exit_pc = 'h1111; step(); core1_exit = 0;
      repeat (20) begin
         chk("bp_jv", join_valid, 1); chk("bp_jpc", join_pc, 'h1111); chk("bp_nocopy", core1_reg_runtime, 0);
         step();
      end
      join_ack = 1; step(); join_ack = 0;
      chk("bp_idle", busy, 0);
      step();
      chk("bp_copy", core1_reg_runtime, 1);
      run_to_load('h200);
      run_to_load('h300);
      step(); chk("qf_empty", busy, 0);

      // Watchdog expiry with no exit.
      fork_valid = 1; fork_pc = 'h700; step(); fork_valid = 0;
      nw = 0;
      for (int i = 0; i < 60 && !join_valid; i++) begin if (core1_wake) nw++; step(); end
      chk("wd_wake_cnt", nw, TO); chk("wd_to", join_timeout, 1); chk("wd_pc", join_pc, 'h700);
      join_ack = 1; step(); join_ack = 0;

      // Exit on the terminal-count cycle is a normal exit.
      fork_valid = 1; fork_pc = 'h780; step(); fork_valid = 0;
      nw = 0;
      for (int i = 0; i < 60 && nw < TO; i++) begin step(); if (core1_wake) nw++; end
      core1_exit = 1; core1_exit_pc = 'hBEEF; step(); core1_exit = 0;
      chk("tc_jv", join_valid, 1); chk("tc_to", join_timeout, 0); chk("tc_pc", join_pc, 'hBEEF);
      join_ack = 1; step(); join_ack = 0;

      // Load abort during COPY with one request queued.
      fork_valid = 1; fork_pc = 'h800; step(); fork_pc = 'h900; step(); fork_valid = 0;
      chk("la_copy", core1_reg_runtime, 1);
      load = 1; step();
      chk("la_busy", busy, 0); chk("la_qc", queue_count, 0); chk("la_regrt", core1_reg_runtime, 0);
      fork_valid = 1; fork_pc = 'h950; step();
      chk("la_ready", fork_ready, 0); chk("la_qc2", queue_count, 0);
      fork_valid = 0; load = 0; step();

      // Reset mid-RUN, then a normal-latency dispatch.
      fork_valid = 1; fork_pc = 'hA00; step(); fork_valid = 0;
      for (int i = 0; i < 30 && !core1_wake; i++) step();
      step();
      reset = 0; step(); reset = 1;
      chk("rr_busy", busy, 0); chk("rr_wake", core1_wake, 0); chk("rr_pc", core1_pc, 0);
      step();
      single_fork('h500, 'h5A0);

      // Randomized traffic in segments with different exit rates.
      flush();
      for (int seg = 0; seg < 3; seg++) begin
         ex_pct = (seg == 0) ? 10 : (seg == 1) ? 0 : 5;
         repeat (1500) begin
            fork_valid    = ($urandom_range(99) < 40);
            fork_pc       = $urandom;
            core1_exit    = ($urandom_range(99) < ex_pct);
            core1_exit_pc = $urandom;
            join_ack      = ($urandom_range(99) < 30);
            load          = ($urandom_range(199) == 0);
            reset         = !($urandom_range(299) == 0);
            step();
         end
      end
      reset = 1; load = 0; fork_valid = 0; core1_exit = 0; join_ack = 0;
      step();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
